// File: rtl/serial_add_pkg.sv
// Shared types and constants for the nibble-serial adder.
// Holds the controller state encoding and the nibble geometry.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W    = 4;
  localparam int NIBBLE_LOG2 = 2;

endpackage

// File: rtl/four_bit_adder_s.sv
// Combinational 4-bit ripple-carry adder: sum/cout settle in the same cycle.
// No state, no flow control.
module four_bit_adder_s
  import serial_add_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[NIBBLE_W];

endmodule

// File: rtl/serial_add_ctrl.sv
// Nibble-serial adder, WIDTH/4 cycles accept-to-result; single op in flight, result held until out_ready.
// Optional signed overflow output when SERIAL_ADD_OVF_EN is defined.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             input_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             output_carry,
  output logic             busy
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t state;
  state_t state_nxt;

  logic accept;
  logic step;
  logic last;

  logic [IDX_W-1:0]         idx;
  logic [IDX_W+NIBBLE_LOG2-1:0] bit_ofs;
  logic [WIDTH-1:0]         a_q;
  logic [WIDTH-1:0]         b_q;
  logic [WIDTH-1:0]         sum_q;
  logic                     carry_q;
  logic                     cout_q;

  logic [NIBBLE_W-1:0]      nib_a;
  logic [NIBBLE_W-1:0]      nib_b;
  logic [NIBBLE_W-1:0]      nib_sum;
  logic                     nib_cout;

  // ---------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign last = (idx == LAST_IDX);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    accept    = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        // Returning to IDLE first keeps a result handshake and a new accept in separate cycles.
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------
  // Nibble datapath
  // ---------------------------------------------------------------
  assign bit_ofs = {idx, {NIBBLE_LOG2{1'b0}}};
  assign nib_a   = a_q[bit_ofs +: NIBBLE_W];
  assign nib_b   = b_q[bit_ofs +: NIBBLE_W];

  four_bit_adder_s u_adder (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else if (accept) begin
      idx     <= '0;
      a_q     <= a;
      b_q     <= b;
      carry_q <= input_carry;
    end else if (step) begin
      sum_q[bit_ofs +: NIBBLE_W] <= nib_sum;
      carry_q                    <= nib_cout;
      // idx parks on the last nibble rather than wrapping.
      if (last) begin
        cout_q <= nib_cout;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign sum          = sum_q;
  assign output_carry = cout_q;

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q;

  // The MSB of the result is bit 3 of the final nibble, so overflow is known on DONE entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (step && last) begin
      ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (nib_sum[NIBBLE_W-1] != a_q[WIDTH-1]);
    end
  end

  assign overflow = ovf_q;
`endif

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand width in bits; it SHALL be a multiple of 4 and at least 8.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: operands are offered.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-006 The block SHALL have ports a and b, input, WIDTH bits each: the addends.
REQ-007 The block SHALL have port input_carry, input, 1 bit: the carry into nibble 0.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the result is available.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-010 The block SHALL have port sum, output, WIDTH bits: the result.
REQ-011 The block SHALL have port output_carry, output, 1 bit: the carry out of the MSB nibble.
REQ-012 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-013 The block SHALL have port overflow, output, 1 bit, present only when SERIAL_ADD_OVF_EN is defined: signed overflow of the result.

Function
REQ-014 The block SHALL implement a state machine with states IDLE, RUN and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-015 In IDLE, when in_valid and in_ready are both 1, the block SHALL register a, b and input_carry, clear the nibble index to 0, and move to RUN.
REQ-016 In RUN, each cycle SHALL add nibble idx of the registered a and b plus the carry register through one 4-bit ripple adder.
- The sum is written into nibble idx of the sum register.
- The carry register takes the adder's carry out.
- idx increments.
REQ-017 RUN SHALL move to DONE on the cycle that processes nibble WIDTH/4-1.
- out_valid SHALL rise exactly WIDTH/4 cycles after the accept edge (4 cycles at WIDTH=16).
REQ-018 In DONE, sum, output_carry and overflow SHALL hold stable until out_valid and out_ready are both 1; the block SHALL then move to IDLE on that edge.
REQ-019 Changes on a, b, input_carry or in_valid outside the accept cycle SHALL NOT affect an operation in progress.
REQ-020 sum and output_carry SHALL equal the full-width result: {output_carry, sum} = a + b + input_carry, modulo 2^(WIDTH+1).
REQ-021 A new operation SHALL NOT be accepted in the same cycle as a result handshake; the minimum issue interval is WIDTH/4+2 cycles.
REQ-022 The nibble index SHALL be ceil(log2(WIDTH/4)) bits wide; it SHALL never exceed WIDTH/4-1 and SHALL NOT wrap while in RUN.

Reset
REQ-023 Asserting rst_n low SHALL, immediately and in any state including mid-RUN:
- force the state to IDLE;
- clear idx, the operand registers, the carry register, sum, output_carry and overflow to 0;
- clear out_valid and busy to 0;
- set in_ready to 1.
REQ-024 Any operation in progress at reset SHALL be discarded without producing a result.

Configuration
REQ-025 With SERIAL_ADD_OVF_EN defined, the block SHALL provide port overflow, registered on entry to DONE.
- overflow = (a[WIDTH-1] == b[WIDTH-1]) and (sum[WIDTH-1] != a[WIDTH-1]).
- overflow SHALL be held with the result through DONE.
REQ-026 With SERIAL_ADD_OVF_EN undefined, the block SHALL have no overflow port and no overflow logic; all other behaviour SHALL be identical.

Structure
REQ-027 A shared package serial_add_pkg SHALL hold:
- the state enumeration type (IDLE, RUN, DONE);
- the constant NIBBLE_W = 4.
REQ-028 The block SHALL instantiate exactly one existing 4-bit ripple adder, four_bit_adder_s, as its only sub-module.
REQ-029 All sequencing, operand storage and result storage SHALL reside in serial_add_ctrl.

Verification
REQ-030 The bench SHALL offer a=0x1234, b=0x4321, input_carry=0 -> sum=0x5555 and output_carry=0, with out_valid high 4 cycles after the accept edge.
REQ-031 The bench SHALL offer a=0xFFFF, b=0x0001, input_carry=0 -> sum=0x0000 and output_carry=1, proving the carry passes through all nibbles.
REQ-032 With SERIAL_ADD_OVF_EN defined, the bench SHALL offer a=0x7FFF, b=0x0001 -> sum=0x8000 and overflow=1; it SHALL then offer a=0x8000, b=0x8000 -> sum=0x0000, output_carry=1 and overflow=1.
REQ-033 The bench SHALL hold out_ready=0 for 5 cycles in DONE -> sum, output_carry, out_valid=1 and in_ready=0 stay constant; when out_ready rises, the block SHALL be back in IDLE with in_ready=1 on the next cycle.
REQ-034 The bench SHALL toggle a, b and in_valid during RUN -> the result SHALL reflect only the operands captured at accept.
REQ-035 The bench SHALL drive rst_n low in the 2nd RUN cycle -> outputs zero, busy=0 and in_ready=1 at once, and no out_valid pulse follows.
